// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: drain FSM states, entry layout, alignment constants.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } sb_state_t;

  // Entry fields are sized to the widest supported address/data; narrower
  // instances use the low bits.
  localparam int SB_AW = 64;
  localparam int SB_DW = 64;

  localparam int DW_BYTES    = 8;
  localparam int ALIGN_SHIFT = $clog2(DW_BYTES);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding select over the buffered entries.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [AW-1:0]    ld_addr,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [PW-1:0] idx;
  logic          unused_low_bits;

  assign unused_low_bits = ^ld_addr[ALIGN_SHIFT-1:0];

  // Walk oldest to youngest starting at head so the last match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] &&
          (entries[idx].addr[AW-1:ALIGN_SHIFT] == ld_addr[AW-1:ALIGN_SHIFT])) begin
        hit  = 1'b1;
        data = entries[idx].data[DW-1:0];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order doubleword store buffer: queues core stores, drains them one at a time
// to data memory and forwards buffered data to a same-cycle load lookup.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  input  logic [AW-1:0]   st_addr,
  input  logic [DW-1:0]   st_data,
  output logic            st_ready,
  input  logic [AW-1:0]   ld_addr,
  output logic            fwd_hit,
  output logic [DW-1:0]   fwd_data,
  output logic            mem_wvalid,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_wready,
  input  logic            mem_ack,
  output logic            sb_empty,
  output sb_state_t       fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: a store transfers on a clock edge where st_valid && st_ready;
  // a memory request transfers on an edge where mem_wvalid && mem_wready, after
  // which the head stays buffered until the mem_ack pulse retires it.

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, count_next;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    offset;
  sb_state_t        state, state_next;
  logic             push, pop;

  assign st_ready = (count != CW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign pop      = (state == WAIT) && mem_ack;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // A push into an empty buffer starts the request on the very next cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if ((count != '0) || push) state_next = REQ;
      REQ:     if (mem_wready) state_next = WAIT;
      WAIT:    if (mem_ack) state_next = (count_next != '0) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail].addr <= SB_AW'(st_addr);
      entries[tail].data <= SB_DW'(st_data);
    end
  end

  // Live entries are the count slots starting at head, wrapping mod DEPTH.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PW'(i) - head;
      valid[i] = ({1'b0, offset} < count);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .ld_addr (ld_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign mem_wvalid = (state == REQ);
  assign mem_waddr  = entries[head].addr[AW-1:0];
  assign mem_wdata  = entries[head].data[DW-1:0];
  assign sb_empty   = (count == '0) && (state == IDLE);
  assign fsm_state  = state;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits downstream of the single-cycle RV64 core and consumes its store outputs (memwrite, address, data).
- Queues doubleword stores in a small in-order FIFO and drains them to data memory over a valid/ready request plus ack-completion interface, one store outstanding at a time.
- Forwards buffered store data to a same-cycle load lookup.
- Reports empty so the core can drain before ebreak/finish.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- AW, 64, address width.
- DW, 64, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock domain.
- st_valid  input  1  store request from core (core memwrite).
- st_addr  input  AW  store address (core address).
- st_data  input  DW  store data (core data).
- st_ready  output  1  buffer can accept a store this cycle.
- ld_addr  input  AW  load lookup address.
- fwd_hit  output  1  a buffered store matches ld_addr.
- fwd_data  output  DW  data of the youngest matching entry.
- mem_wvalid  output  1  write request valid.
- mem_waddr  output  AW  write address = head entry address.
- mem_wdata  output  DW  write data = head entry data.
- mem_wready  input  1  memory accepts request.
- mem_ack  input  1  memory write complete (single-cycle pulse).
- sb_empty  output  1  no entries and FSM in IDLE.

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed): head, tail and count = 0; FSM = IDLE; mem_wvalid = 0; st_ready = 1; fwd_hit = 0; fwd_data = 0; sb_empty = 1. Entry contents are don't-care.
- Push:
  - Occurs when st_valid && st_ready at a clock edge: write entry[tail] = {st_addr, st_data}, tail++ (wraps mod DEPTH), count++.
  - st_ready = (count != DEPTH). There is no same-cycle bypass: when full, st_ready stays 0 even if a pop happens that cycle.
  - Store-to-mem latency: a store pushed into an empty buffer makes mem_wvalid = 1 on the next cycle.
- Drain FSM, states IDLE, REQ, WAIT:
  - IDLE: if count != 0, go to REQ.
  - REQ: mem_wvalid = 1 with the head address/data. Address and data are held stable until mem_wready. On mem_wready, go to WAIT.
  - WAIT: mem_wvalid = 0. On mem_ack: pop the head (head++ wraps, count--), then go to REQ if count-after-pop != 0, else IDLE.
  - mem_ack outside WAIT is ignored.
  - mem_wready and mem_ack in the same cycle while in REQ: only the request handshake counts; the ack is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Forwarding (combinational):
  - Compare ld_addr[AW-1:3] against addr[AW-1:3] of every valid entry, including the head entry while it is in REQ or WAIT.
  - fwd_hit = any match. fwd_data = data of the youngest match, i.e. nearest to tail in FIFO order.
  - A store being pushed in the same cycle is not visible until the next cycle.
  - No match gives fwd_hit = 0, fwd_data = 0.
- Width rules: all stores are 8-byte doublewords; addr[2:0] is ignored for matching and passed through unchanged on mem_waddr. Count is $clog2(DEPTH)+1 bits.
- sb_empty = (count == 0) && (state == IDLE).
- Reset mid-operation: pending entries are discarded and mem_wvalid drops asynchronously. A late mem_ack after reset is ignored because the FSM is in IDLE.

Decomposition:
- Shared package store_buffer_pkg holds:
  - sb_state_t enum {IDLE, REQ, WAIT}.
  - Entry struct {addr, data}.
  - The DW_BYTES=8 constant for the alignment shift.
- Sub-module sb_fwd_match: combinational youngest-match priority select over DEPTH entries. Inputs: entry array, valid vector, head index, ld_addr. Outputs: hit, data.

Test Plan:
- Single store: push addr=0x80000010, data=0xDEADBEEF_00000001; hold mem_wready=1, pulse mem_ack 2 cycles later -> mem_wvalid high exactly one cycle after push with the matching addr/data; sb_empty returns to 1 the cycle after the ack.
- Fill: push 5 stores back-to-back with mem_wready=0 -> the first 4 are accepted; st_ready=0 from the cycle after the 4th push; the 5th is held until the first ack pops an entry.
- Backpressure: mem_wready low for 10 cycles -> mem_wvalid, mem_waddr and mem_wdata stay stable the whole time; the handshake completes on the first wready=1.
- Forwarding priority: push 0x1000 with 0xAA, 0x2000 with 0xBB, then 0x1004 with 0xCC; set ld_addr=0x1000 -> fwd_hit=1, fwd_data=0xCC. ld_addr=0x3000 -> fwd_hit=0, fwd_data=0.
- Wrap and simultaneous push/pop: stream 12 stores while acking each 3 cycles after its request -> memory receives all 12 in order; count never exceeds DEPTH; pointers wrap correctly.
- Reset mid-drain: assert rst=0 while in WAIT with 3 entries -> mem_wvalid=0, st_ready=1, sb_empty=1 immediately; a following mem_ack causes no pop and no request.
